// File: rtl/rv32m_muldiv.sv
// rv32m_muldiv: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Define RV32M_DIV_EN to build the divide datapath; without it divide ops finish at once and flag illegal.
module rv32m_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [2:0]         op_r;
  logic               neg_r;
  logic               busy_r;
  logic               done_r;
  logic               illegal_r;
  logic [WIDTH-1:0]   result_r;

  logic               a_sgn_s;
  logic               b_sgn_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_step_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   mul_res_s;
  logic [WIDTH-1:0]   div_res_s;
  logic [WIDTH-1:0]   fin_result_s;

`ifdef RV32M_DIV_EN
  logic [WIDTH-1:0]   a_r;
  logic               neg_rem_r;
  logic               div0_r;
  logic               ovf_r;
  logic               div0_s;
  logic               ovf_s;
  logic [WIDTH:0]     div_trial_s;
  logic [2*WIDTH-1:0] div_step_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
`endif

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic n);
    cneg = n ? -v : v;
  endfunction

  // Operand signedness per op and magnitudes fed to the unsigned iteration
  always_comb begin
    if (funct3[2]) begin
      a_sgn_s = ~funct3[0];
      b_sgn_s = ~funct3[0];
    end else begin
      a_sgn_s = (funct3[1:0] == 2'b01) | (funct3[1:0] == 2'b10);
      b_sgn_s = (funct3[1:0] == 2'b01);
    end
    a_neg_s = a_sgn_s & a[WIDTH-1];
    b_neg_s = b_sgn_s & b[WIDTH-1];
    mag_a_s = cneg(a, a_neg_s);
    mag_b_s = cneg(b, b_neg_s);
  end

`ifdef RV32M_DIV_EN
  assign div0_s = (b == {WIDTH{1'b0}});
  assign ovf_s  = ~funct3[0] & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (b == {WIDTH{1'b1}});
`endif

  // Next-state decode; flush wins over everything
  always_comb begin
    state_nxt_s = S_IDLE;
    if (flush) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            if (funct3[2]) begin
`ifdef RV32M_DIV_EN
              state_nxt_s = S_DIV;
`else
              state_nxt_s = S_FIN;
`endif
            end else begin
              state_nxt_s = S_MUL;
            end
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_MUL: state_nxt_s = (cnt_r == CNT_LAST) ? S_FIN : S_MUL;
`ifdef RV32M_DIV_EN
        S_DIV: state_nxt_s = (div0_r | ovf_r | (cnt_r == CNT_LAST)) ? S_FIN : S_DIV;
`else
        S_DIV: state_nxt_s = S_IDLE;
`endif
        S_FIN: state_nxt_s = S_IDLE;
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // Shift-add step: acc holds {partial product, remaining multiplier bits}
  always_comb begin
    mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
    if (acc_r[0]) begin
      mul_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end else begin
      mul_step_s = {1'b0, acc_r[2*WIDTH-1:1]};
    end
    prod_s    = neg_r ? -mul_step_s : mul_step_s;
    mul_res_s = (op_r[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
  end

`ifdef RV32M_DIV_EN
  // Restoring step: acc holds {partial remainder, remaining dividend / quotient bits}
  always_comb begin
    div_trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]} - {1'b0, opnd_r};
    if (div_trial_s[WIDTH]) begin
      div_step_s = {acc_r[2*WIDTH-2:0], 1'b0};
    end else begin
      div_step_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end
    if (div0_r) begin
      quo_s = {WIDTH{1'b1}};
      rem_s = a_r;
    end else if (ovf_r) begin
      quo_s = a_r;
      rem_s = {WIDTH{1'b0}};
    end else begin
      quo_s = cneg(div_step_s[WIDTH-1:0], neg_r);
      rem_s = cneg(div_step_s[2*WIDTH-1:WIDTH], neg_rem_r);
    end
    div_res_s = op_r[1] ? rem_s : quo_s;
  end
`else
  assign div_res_s = {WIDTH{1'b0}};
`endif

  assign fin_result_s = op_r[2] ? div_res_s : mul_res_s;

  // FSM state, operand capture and iteration datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      cnt_r     <= {CW{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      opnd_r    <= {WIDTH{1'b0}};
      op_r      <= 3'b000;
      neg_r     <= 1'b0;
`ifdef RV32M_DIV_EN
      a_r       <= {WIDTH{1'b0}};
      neg_rem_r <= 1'b0;
      div0_r    <= 1'b0;
      ovf_r     <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      if (state_r == S_IDLE) begin
        if (start && !flush) begin
          op_r  <= funct3;
          cnt_r <= {CW{1'b0}};
          neg_r <= a_neg_s ^ b_neg_s;
          if (!funct3[2]) begin
            acc_r  <= {{WIDTH{1'b0}}, mag_b_s};
            opnd_r <= mag_a_s;
          end
`ifdef RV32M_DIV_EN
          else begin
            acc_r     <= {{WIDTH{1'b0}}, mag_a_s};
            opnd_r    <= mag_b_s;
            a_r       <= a;
            neg_rem_r <= a_neg_s;
            div0_r    <= div0_s;
            ovf_r     <= ovf_s & ~div0_s;
          end
`endif
        end
      end else if (state_r == S_MUL) begin
        acc_r <= mul_step_s;
        cnt_r <= cnt_r + CNT_ONE;
      end
`ifdef RV32M_DIV_EN
      else if (state_r == S_DIV) begin
        acc_r <= div_step_s;
        cnt_r <= cnt_r + CNT_ONE;
      end
`endif
    end
  end

  // Registered outputs, all derived from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
      result_r  <= {WIDTH{1'b0}};
    end else begin
      busy_r <= (state_nxt_s != S_IDLE);
      done_r <= (state_nxt_s == S_FIN);
`ifdef RV32M_DIV_EN
      illegal_r <= 1'b0;
`else
      illegal_r <= (state_nxt_s == S_FIN) && (state_r == S_IDLE);
`endif
      if (state_nxt_s == S_FIN) begin
        result_r <= (state_r == S_IDLE) ? {WIDTH{1'b0}} : fin_result_s;
      end
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign illegal = illegal_r;
  assign result  = result_r;

endmodule
